// File: rtl/bw_io_ddr_impctl_sched.sv
// Calibration scheduler for the DDR impedance pulldown/pullup pair: sequences
// the two units, detects deltabit lock, issues the shared update pulse.
module bw_io_ddr_impctl_sched #(
  parameter int unsigned TIMER_W      = 16,
  parameter int unsigned CAL_PERIOD   = 4096,
  parameter int unsigned MAX_CAL      = 1024,
  parameter int unsigned LOCK_TOGGLES = 4,
  parameter int unsigned UPD_LEN      = 2
) (
  input  logic       rclk,
  input  logic       hard_reset_n,
  input  logic       cal_en,
  input  logic       cal_start,
  input  logic       csr_we,
  input  logic       dn_deltabit,
  input  logic       up_deltabit,
  output logic       dn_clk_dis_l,
  output logic       up_clk_dis_l,
  output logic       upd_imped,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_timeout,
  output logic [7:0] cal_cnt
);

  localparam int unsigned TOG_W = 4;
  localparam int unsigned UPD_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DN_CAL = 2'd1,
    UP_CAL = 2'd2,
    UPDATE = 2'd3
  } state_e;

  state_e             state, next_state;
  logic [TIMER_W-1:0] period_cnt, period_d;
  logic [TIMER_W-1:0] win_cnt, win_d;
  logic [TOG_W-1:0]   tog_cnt, tog_d;
  logic [UPD_W-1:0]   upd_cnt, upd_cnt_d;
  logic               prev_db, prev_db_d;
  logic               pend, pend_d;

  logic               dn_en_d, up_en_d, upd_d, busy_d, done_d, timeout_d;
  logic [CNT_W-1:0]   cnt_d;

  logic               in_cal_c, cur_db_c, lock_c, win_end_c;
  logic               start_req_c, launch_c, upd_end_c;
  logic [TOG_W-1:0]   tog_inc_c;

  // Per-cycle conditions shared by both combinational processes
  assign in_cal_c    = (state == DN_CAL) || (state == UP_CAL);
  assign cur_db_c    = (state == DN_CAL) ? dn_deltabit : up_deltabit;
  assign tog_inc_c   = tog_cnt + TOG_W'(cur_db_c ^ prev_db);
  assign lock_c      = (tog_inc_c == TOG_W'(LOCK_TOGGLES));
  assign win_end_c   = (win_cnt == TIMER_W'(MAX_CAL - 1));
  assign start_req_c = cal_start | (cal_en & (period_cnt == TIMER_W'(CAL_PERIOD - 1)));
  assign launch_c    = (start_req_c | pend) & ~csr_we;
  assign upd_end_c   = (upd_cnt == UPD_W'(UPD_LEN - 1));

  // State and all registered outputs
  always_ff @(posedge rclk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state        <= IDLE;
      period_cnt   <= '0;
      win_cnt      <= '0;
      tog_cnt      <= '0;
      upd_cnt      <= '0;
      prev_db      <= 1'b0;
      pend         <= 1'b0;
      dn_clk_dis_l <= 1'b0;
      up_clk_dis_l <= 1'b0;
      upd_imped    <= 1'b0;
      cal_busy     <= 1'b0;
      cal_done     <= 1'b0;
      cal_timeout  <= 1'b0;
      cal_cnt      <= '0;
    end else begin
      state        <= next_state;
      period_cnt   <= period_d;
      win_cnt      <= win_d;
      tog_cnt      <= tog_d;
      upd_cnt      <= upd_cnt_d;
      prev_db      <= prev_db_d;
      pend         <= pend_d;
      dn_clk_dis_l <= dn_en_d;
      up_clk_dis_l <= up_en_d;
      upd_imped    <= upd_d;
      cal_busy     <= busy_d;
      cal_done     <= done_d;
      cal_timeout  <= timeout_d;
      cal_cnt      <= cnt_d;
    end
  end

  // Next state and counter datapath; a CSR write aborts ahead of lock/timeout
  always_comb begin
    next_state = state;
    period_d   = period_cnt;
    win_d      = win_cnt;
    tog_d      = tog_cnt;
    prev_db_d  = prev_db;
    pend_d     = pend;
    upd_cnt_d  = '0;

    case (state)
      IDLE: begin
        if (start_req_c || launch_c) begin
          period_d = '0;
        end else if (cal_en) begin
          period_d = period_cnt + TIMER_W'(1);
        end
        if (launch_c) begin
          pend_d     = 1'b0;
          next_state = DN_CAL;
        end else if (start_req_c) begin
          pend_d = 1'b1;
        end
      end
      DN_CAL: begin
        if (csr_we) begin
          next_state = IDLE;
          period_d   = '0;
        end else if (lock_c || win_end_c) begin
          next_state = UP_CAL;
        end
      end
      UP_CAL: begin
        if (csr_we) begin
          next_state = IDLE;
          period_d   = '0;
        end else if (lock_c || win_end_c) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        upd_cnt_d = upd_cnt + UPD_W'(1);
        if (upd_end_c) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    // Entering a unit snapshots its deltabit; staying in it tracks transitions
    if (next_state == DN_CAL && state != DN_CAL) begin
      prev_db_d = dn_deltabit;
      win_d     = '0;
      tog_d     = '0;
    end else if (next_state == UP_CAL && state != UP_CAL) begin
      prev_db_d = up_deltabit;
      win_d     = '0;
      tog_d     = '0;
    end else if (in_cal_c) begin
      prev_db_d = cur_db_c;
      win_d     = win_cnt + TIMER_W'(1);
      tog_d     = tog_inc_c;
    end
  end

  // Registered-output next values, derived from the upcoming state
  always_comb begin
    dn_en_d   = 1'b0;
    up_en_d   = 1'b0;
    upd_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    timeout_d = cal_timeout;
    cnt_d     = cal_cnt;

    dn_en_d = (next_state == DN_CAL);
    up_en_d = (next_state == UP_CAL);
    upd_d   = (next_state == UPDATE);
    busy_d  = (next_state != IDLE);

    if ((state == UPDATE) && upd_end_c) begin
      done_d = 1'b1;
      cnt_d  = cal_cnt + CNT_W'(1);
    end

    if ((state == IDLE) && cal_start) begin
      timeout_d = 1'b0;
    end else if (in_cal_c && !csr_we && !lock_c && win_end_c) begin
      timeout_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_bw_io_ddr_impctl_sched.sv
// Self-checking bench for bw_io_ddr_impctl_sched: directed scenarios plus
// randomized traffic compared against a phase/age reference model.
module tb_bw_io_ddr_impctl_sched;

  localparam int unsigned CAL_PERIOD = 16;
  localparam int unsigned MAX_CAL    = 32;
  localparam int unsigned LOCK       = 4;
  localparam int unsigned UPD_LEN    = 2;

  localparam int M_IDLE = 0;
  localparam int M_DN   = 1;
  localparam int M_UP   = 2;
  localparam int M_UPD  = 3;

  logic       rclk = 1'b0;
  logic       hard_reset_n;
  logic       cal_en, cal_start, csr_we, dn_deltabit, up_deltabit;
  logic       dn_clk_dis_l, up_clk_dis_l, upd_imped, cal_busy, cal_done, cal_timeout;
  logic [7:0] cal_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference model: which phase we are in and how long we have been there
  int         m_mode, m_age, m_tog, m_period;
  logic       m_last, m_pend, m_done, m_to;
  logic [7:0] m_cnt;

  bw_io_ddr_impctl_sched #(
    .TIMER_W(16), .CAL_PERIOD(CAL_PERIOD), .MAX_CAL(MAX_CAL),
    .LOCK_TOGGLES(LOCK), .UPD_LEN(UPD_LEN)
  ) dut (
    .rclk(rclk), .hard_reset_n(hard_reset_n), .cal_en(cal_en),
    .cal_start(cal_start), .csr_we(csr_we), .dn_deltabit(dn_deltabit),
    .up_deltabit(up_deltabit), .dn_clk_dis_l(dn_clk_dis_l),
    .up_clk_dis_l(up_clk_dis_l), .upd_imped(upd_imped), .cal_busy(cal_busy),
    .cal_done(cal_done), .cal_timeout(cal_timeout), .cal_cnt(cal_cnt)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE; m_age = 0; m_tog = 0; m_period = 0;
    m_last = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_to = 1'b0; m_cnt = '0;
  endfunction

  function automatic void model_enter(input int mode, input logic db);
    m_mode = mode; m_age = 0; m_tog = 0; m_last = db;
  endfunction

  // Advance the model by one rclk edge using the inputs present at that edge
  function automatic void model_step();
    logic req, db;
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
        req = cal_start || (cal_en && m_period == int'(CAL_PERIOD) - 1);
        if (cal_start) m_to = 1'b0;
        if (req) begin
          m_period = 0;
          m_pend   = 1'b1;
        end else if (cal_en) begin
          m_period++;
        end
        if (m_pend && !csr_we) begin
          m_pend   = 1'b0;
          m_period = 0;
          model_enter(M_DN, dn_deltabit);
        end
      end
      M_DN, M_UP: begin
        db = (m_mode == M_DN) ? dn_deltabit : up_deltabit;
        if (csr_we) begin
          m_mode   = M_IDLE;
          m_period = 0;
        end else begin
          if (db !== m_last) m_tog++;
          m_last = db;
          m_age++;
          if (m_tog == int'(LOCK) || m_age == int'(MAX_CAL)) begin
            if (m_tog != int'(LOCK)) m_to = 1'b1;
            if (m_mode == M_DN) model_enter(M_UP, up_deltabit);
            else                model_enter(M_UPD, 1'b0);
          end
        end
      end
      M_UPD: begin
        m_age++;
        if (m_age == int'(UPD_LEN)) begin
          m_mode = M_IDLE;
          m_done = 1'b1;
          m_cnt  = m_cnt + 8'd1;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  task automatic check_model();
    logic [13:0] obs, exp;
    obs = {dn_clk_dis_l, up_clk_dis_l, upd_imped, cal_busy, cal_done, cal_timeout, cal_cnt};
    exp = {m_mode == M_DN, m_mode == M_UP, m_mode == M_UPD, m_mode != M_IDLE,
           m_done, m_to, m_cnt};
    check("model_outs", 16'(obs), 16'(exp));
    check("one_clk_en", 16'(dn_clk_dis_l & up_clk_dis_l), 16'd0);
  endtask

  task automatic tick();
    @(posedge rclk);
    model_step();
    #1;
    cyc++;
    check_model();
  endtask

  task automatic do_reset();
    hard_reset_n = 1'b0;
    cal_en = 1'b0; cal_start = 1'b0; csr_we = 1'b0;
    dn_deltabit = 1'b0; up_deltabit = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    hard_reset_n = 1'b1;
    cyc = 0;
    check_model();
  endtask

  initial begin
    int p_dn, p_up;

    // Nominal calibration, then an abort in the 3rd UP_CAL cycle
    do_reset();
    check("rst_cnt", 16'(cal_cnt), 16'd0);
    check("rst_busy", 16'(cal_busy), 16'd0);
    for (int c = 0; c < 36; c++) begin
      cal_start   = (c == 5) || (c == 20);
      csr_we      = (c == 27);
      dn_deltabit = 1'(c & 1);
      up_deltabit = 1'(c & 1);
      tick();
      if (cyc <= 18) begin
        check("t1_dn",   16'(dn_clk_dis_l), 16'(cyc >= 6 && cyc <= 9));
        check("t1_up",   16'(up_clk_dis_l), 16'(cyc >= 10 && cyc <= 13));
        check("t1_upd",  16'(upd_imped),    16'(cyc == 14 || cyc == 15));
        check("t1_done", 16'(cal_done),     16'(cyc == 16));
      end else begin
        check("t4_up",   16'(up_clk_dis_l), 16'(cyc >= 25 && cyc <= 27));
        check("t4_busy", 16'(cal_busy),     16'(cyc >= 21 && cyc <= 27));
        check("t4_upd",  16'(upd_imped),    16'd0);
        check("t4_done", 16'(cal_done),     16'd0);
        check("t4_cnt",  16'(cal_cnt),      16'd1);
      end
      if (cyc == 16) begin
        check("t1_cnt", 16'(cal_cnt),     16'd1);
        check("t1_to",  16'(cal_timeout), 16'd0);
      end
    end

    // Periodic calibration, three back-to-back periods
    do_reset();
    for (int c = 0; c < 80; c++) begin
      cal_en      = 1'b1;
      dn_deltabit = 1'(c & 1);
      up_deltabit = 1'(c & 1);
      tick();
      check("t2_dn", 16'(dn_clk_dis_l),
            16'((cyc >= 16 && cyc <= 19) || (cyc >= 42 && cyc <= 45) || (cyc >= 68 && cyc <= 71)));
      check("t2_done", 16'(cal_done), 16'(cyc == 26 || cyc == 52 || cyc == 78));
    end
    check("t2_cnt", 16'(cal_cnt), 16'd3);

    // Stuck pulldown deltabit forces a timeout; sticky until the next cal_start
    do_reset();
    for (int c = 0; c < 54; c++) begin
      cal_start   = (c == 5) || (c == 50);
      csr_we      = (c == 52);
      dn_deltabit = 1'b0;
      up_deltabit = 1'(c & 1);
      tick();
      if (cyc <= 50) begin
        check("t3_dn", 16'(dn_clk_dis_l), 16'(cyc >= 6 && cyc <= 37));
        check("t3_up", 16'(up_clk_dis_l), 16'(cyc >= 38 && cyc <= 41));
      end
      check("t3_to", 16'(cal_timeout), 16'(cyc >= 38 && cyc <= 50));
    end

    // Start coinciding with a 3-cycle CSR write is deferred
    do_reset();
    for (int c = 0; c < 19; c++) begin
      cal_start   = (c == 5);
      csr_we      = (c >= 5 && c <= 7);
      dn_deltabit = 1'(c & 1);
      up_deltabit = 1'(c & 1);
      tick();
      check("t5_dn",   16'(dn_clk_dis_l), 16'(cyc >= 9 && cyc <= 12));
      check("t5_busy", 16'(cal_busy),     16'(cyc >= 9 && cyc <= 18));
    end
    check("t5_cnt", 16'(cal_cnt), 16'd1);

    // Asynchronous reset while the update pulse is high
    do_reset();
    for (int c = 0; c < 14; c++) begin
      cal_start   = (c == 5);
      dn_deltabit = 1'(c & 1);
      up_deltabit = 1'(c & 1);
      tick();
    end
    check("t6_upd_hi", 16'(upd_imped), 16'd1);
    #3;
    hard_reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_upd_lo", 16'(upd_imped), 16'd0);
    check("t6_busy",   16'(cal_busy),  16'd0);
    check_model();
    @(negedge rclk);
    hard_reset_n = 1'b1;
    cyc = 0;
    cal_start = 1'b0;
    repeat (3) tick();
    check("t6_cnt", 16'(cal_cnt), 16'd0);

    // Randomized traffic with varying deltabit activity against the model
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      p_dn = (seg == 0) ? 90 : (seg == 1) ? 50 : (seg == 2) ? 3 : 20;
      p_up = (seg == 0) ? 60 : (seg == 1) ? 4  : (seg == 2) ? 70 : 15;
      for (int c = 0; c < 800; c++) begin
        cal_en    = ($urandom_range(99) < 90);
        cal_start = ($urandom_range(99) < 2);
        csr_we    = ($urandom_range(99) < 3);
        if ($urandom_range(99) < p_dn) dn_deltabit = ~dn_deltabit;
        if ($urandom_range(99) < p_up) up_deltabit = ~up_deltabit;
        tick();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
